fifo_rd_ctrl: RTL

//  Read-domain controller for the async FIFO; parametrised successor of the fixed 4-bit read-pointer block.

---
 rtl/fifo_rd_ctrl.sv | 74 +++++++
 1 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: binary read pointer for the RAM,
// Gray read pointer for the write domain, and registered empty/level flags.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AEMPTY_TH  = 1
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rinc,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic                  rempty,
  output logic                  raempty,
  output logic [ADDR_WIDTH:0]   rlevel,
  output logic                  runderflow
);

  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] AE_TH = PTR_W'(AEMPTY_TH);

  logic [PTR_W-1:0] rbin_q, rbin_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] rlevel_q, rlevel_d;
  logic [PTR_W-1:0] wbin;
  logic             rempty_q, rempty_d;
  logic             raempty_q, raempty_d;
  logic             runderflow_q, runderflow_d;
  logic             rd_en;

  // Gray-to-binary: each bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi < PTR_W; gi++) begin : g_g2b
      assign wbin[gi] = ^(rq2_wptr >> gi);
    end
  endgenerate

  always_comb begin
    rd_en        = rinc & ~rempty_q;
    rbin_d       = rbin_q + PTR_W'(rd_en);
    rptr_d       = rbin_d ^ (rbin_d >> 1);
    rlevel_d     = wbin - rbin_d;
    rempty_d     = (rptr_d == rq2_wptr);
    raempty_d    = (rlevel_d <= AE_TH);
    runderflow_d = rinc & rempty_q;
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rlevel_q     <= '0;
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rlevel_q     <= rlevel_d;
      rempty_q     <= rempty_d;
      raempty_q    <= raempty_d;
      runderflow_q <= runderflow_d;
    end
  end

  assign raddr      = rbin_q[ADDR_WIDTH-1:0];
  assign rptr       = rptr_q;
  assign rempty     = rempty_q;
  assign raempty    = raempty_q;
  assign rlevel     = rlevel_q;
  assign runderflow = runderflow_q;

endmodule
